// File: rtl/icache_refill_controller.sv
// I-cache line refill sequencer: miss -> line request -> 16 word writes -> tag write.
// Ports: clk/rst, miss+hit inputs, mem req/rsp, data-array write, tag write, busy/done. Option: ICACHE_PLRU_EN.
module icache_refill_controller #(
  parameter int ICACHE_NUM_WAYS = 4,
  parameter int ICACHE_NUM_SETS = 64,
  parameter int ICACHE_CL_SIZE  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cache_miss,
  input  logic [31:0]                miss_addr,
  input  logic                       hit_valid,
  input  logic [1:0]                 hit_way,
  input  logic [5:0]                 hit_set,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [31:0]                mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [31:0]                mem_rsp_data,
  output logic                       data_wr_en,
  output logic [1:0]                 data_wr_way,
  output logic [5:0]                 data_wr_set,
  output logic [3:0]                 data_wr_word,
  output logic [31:0]                data_wr_data,
  output logic [ICACHE_NUM_WAYS-1:0] update_tag_en,
  output logic [5:0]                 update_tag_set,
  output logic [19:0]                update_tag,
  output logic                       refill_busy,
  output logic                       refill_done
);

  localparam int WORDS = ICACHE_CL_SIZE / 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_UPD  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [25:0] line_q, line_d;
  logic [1:0]  way_q, way_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  victim;

  wire unused_addr = ^miss_addr[5:0];

`ifdef ICACHE_PLRU_EN
  // Tree bit 0 picks the pair (1 = ways 2/3), bit 1/2 pick within a pair.
  logic [ICACHE_NUM_SETS-1:0][2:0] plru_q, plru_d;
  logic [2:0] miss_tree;

  function automatic logic [2:0] touch(input logic [2:0] t,
                                       input logic [1:0] w);
    logic [2:0] r;
    r = t;
    r[0] = ~w[1];
    if (w[1]) r[2] = ~w[0];
    else      r[1] = ~w[0];
    return r;
  endfunction

  assign miss_tree = plru_q[miss_addr[11:6]];
  assign victim = miss_tree[0] ? {1'b1, miss_tree[2]}
                               : {1'b0, miss_tree[1]};

  // Refill touch comes after the hit touch so it wins on a same-set clash.
  always_comb begin
    plru_d = plru_q;
    if (hit_valid)
      plru_d[hit_set] = touch(plru_d[hit_set], hit_way);
    if (state_q == S_UPD)
      plru_d[line_q[5:0]] = touch(plru_d[line_q[5:0]], way_q);
  end

  always_ff @(posedge clk) begin
    if (rst) plru_q <= '0;
    else     plru_q <= plru_d;
  end
`else
  logic [1:0] rr_q, rr_d;
  wire unused_hit = ^{hit_valid, hit_way, hit_set};

  assign victim = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (state_q == S_UPD) rr_d = rr_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`endif

  always_comb begin
    state_d        = state_q;
    line_d         = line_q;
    way_d          = way_q;
    cnt_d          = cnt_q;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    data_wr_en     = 1'b0;
    data_wr_way    = '0;
    data_wr_set    = '0;
    data_wr_word   = '0;
    data_wr_data   = '0;
    update_tag_en  = '0;
    update_tag_set = '0;
    update_tag     = '0;
    refill_done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cache_miss) begin
          line_d  = miss_addr[31:6];
          way_d   = victim;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {line_q, 6'b0};
        if (mem_req_ready) state_d = S_FILL;
      end
      S_FILL: begin
        if (mem_rsp_valid) begin
          data_wr_en   = 1'b1;
          data_wr_way  = way_q;
          data_wr_set  = line_q[5:0];
          data_wr_word = cnt_q;
          data_wr_data = mem_rsp_data;
          cnt_d        = cnt_q + 4'd1;
          if (cnt_q == 4'(WORDS - 1)) state_d = S_UPD;
        end
      end
      S_UPD: begin
        update_tag_en[way_q] = 1'b1;
        update_tag_set       = line_q[5:0];
        update_tag           = line_q[25:6];
        refill_done          = 1'b1;
        state_d              = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign refill_busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_controller.sv
// Scoreboard bench for icache_refill_controller (default round-robin build).
// Stimulus pushes expected requests/writes/tag updates; a negedge monitor pops and compares.
module tb_icache_refill_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cache_miss = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        hit_valid = 1'b0;
  logic [1:0]  hit_way = '0;
  logic [5:0]  hit_set = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        data_wr_en;
  logic [1:0]  data_wr_way;
  logic [5:0]  data_wr_set;
  logic [3:0]  data_wr_word;
  logic [31:0] data_wr_data;
  logic [3:0]  update_tag_en;
  logic [5:0]  update_tag_set;
  logic [19:0] update_tag;
  logic        refill_busy;
  logic        refill_done;

  icache_refill_controller dut (
    .clk(clk), .rst(rst),
    .cache_miss(cache_miss), .miss_addr(miss_addr),
    .hit_valid(hit_valid), .hit_way(hit_way), .hit_set(hit_set),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .data_wr_en(data_wr_en), .data_wr_way(data_wr_way),
    .data_wr_set(data_wr_set), .data_wr_word(data_wr_word),
    .data_wr_data(data_wr_data),
    .update_tag_en(update_tag_en), .update_tag_set(update_tag_set),
    .update_tag(update_tag),
    .refill_busy(refill_busy), .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  way;
    logic [5:0]  set;
    logic [3:0]  word;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [3:0]  en;
    logic [5:0]  set;
    logic [19:0] tag;
  } tag_t;

  logic [31:0] req_q[$];
  wr_t         wr_q[$];
  tag_t        tag_q[$];

  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    cmp++;
    bad++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  function automatic logic [127:0] outs();
    return {mem_req_valid, mem_req_addr, data_wr_en, data_wr_way,
            data_wr_set, data_wr_word, data_wr_data, update_tag_en,
            update_tag_set, update_tag, refill_busy, refill_done};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid) begin
        if (req_q.size() == 0) unexpected("mem_req");
        else begin
          chk("req_addr", mem_req_addr, req_q[0]);
          if (mem_req_ready) void'(req_q.pop_front());
        end
      end else begin
        chk("req_addr_idle", mem_req_addr, 0);
      end
      if (data_wr_en) begin
        if (wr_q.size() == 0) unexpected("data_wr");
        else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("data_wr", {data_wr_way, data_wr_set, data_wr_word,
                          data_wr_data},
              {e.way, e.set, e.word, e.data});
        end
      end else begin
        chk("data_wr_idle", {data_wr_way, data_wr_set, data_wr_word,
                             data_wr_data}, 0);
      end
      if (update_tag_en != 0 || refill_done) begin
        if (tag_q.size() == 0) unexpected("tag_wr");
        else begin
          tag_t t;
          t = tag_q.pop_front();
          chk("tag_wr", {update_tag_en, update_tag_set, update_tag,
                         refill_done},
              {t.en, t.set, t.tag, 1'b1});
        end
      end else begin
        chk("tag_idle", {update_tag_set, update_tag}, 0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      hit_valid = 1'($urandom);
      hit_way   = 2'($urandom);
      hit_set   = 6'($urandom);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
  endtask

  task automatic refill(input logic [31:0] addr, input int dly,
                        input int gap, input bit stray,
                        input int rst_at, input int exp_lat);
    logic [1:0] v;
    int t0;
    int lat;
    v = 2'(done_cnt % 4);
    @(posedge clk);
    #1;
    t0 = cyc;
    cache_miss = 1'b1;
    miss_addr  = addr;
    req_q.push_back({addr[31:6], 6'b0});
    @(posedge clk);
    #1;
    cache_miss = 1'b0;
    miss_addr  = $urandom;
    repeat (dly) begin
      mem_rsp_valid = 1'($urandom);
      mem_rsp_data  = $urandom;
      @(posedge clk);
      #1;
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    for (int w = 0; w < 16; w++) begin
      if (rst_at != 0 && w == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_cnt = 0;
        @(negedge clk);
        chk("mid_reset_outputs", outs(), 0);
        return;
      end
      if (gap > 0) repeat ($urandom_range(0, gap)) begin
        @(posedge clk);
        #1;
      end
      if (stray && w == 5) begin
        cache_miss = 1'b1;
        miss_addr  = $urandom;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
      wr_q.push_back('{v, addr[11:6], 4'(w), mem_rsp_data});
      if (w == 15) tag_q.push_back('{4'b1 << v, addr[11:6], addr[31:12]});
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      cache_miss    = 1'b0;
    end
    done_cnt++;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!refill_busy) break;
    end
    lat = cyc - t0;
    chk("idle_outputs", outs(), 0);
    if (exp_lat > 0) chk("miss_to_idle", 128'(lat), 128'(exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    refill(32'h0000_1040, 0, 0, 1'b0, 0, 19);
    refill(32'h0000_1040, 5, 0, 1'b0, 0, 0);
    refill(32'h1234_5678, 2, 3, 1'b1, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++)
      refill({20'(i + 5), 12'h000}, 1, 2, 1'b0, 0, 0);
    refill(32'hABCD_E0C0, 0, 1, 1'b0, 8, 0);
    refill(32'h0000_1040, 0, 0, 1'b0, 0, 19);
    for (int i = 0; i < 6; i++)
      refill($urandom, $urandom_range(0, 4), $urandom_range(0, 3),
             1'($urandom), 0, 0);
    repeat (3) @(posedge clk);
    chk("req_q_empty", 128'(req_q.size()), 0);
    chk("wr_q_empty", 128'(wr_q.size()), 0);
    chk("tag_q_empty", 128'(tag_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
